// File: rtl/vga_pkg.sv
// Shared VGA constants and the glyph-writer state encoding.
// The scan-out reader uses the same resolution constants, so the frame
// buffer layout (row stride = H_RES, 1 bit per pixel) is defined only here.
package vga_pkg;

  localparam int H_RES   = 640;  // visible pixels per line, frame-buffer stride
  localparam int V_RES   = 480;  // visible lines
  localparam int GLYPH_W = 8;    // glyph width, matches the font row width
  localparam int GLYPH_H = 8;    // glyph height in rows
  localparam int COLS    = H_RES / GLYPH_W;
  localparam int ROWS    = V_RES / GLYPH_H;
  localparam int ADDR_W  = 19;   // ceil(log2(H_RES*V_RES))

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    WRITE  = 3'd3,
    CLEAR  = 3'd4,
    FINISH = 3'd5
  } writer_state_t;

endpackage

// File: rtl/vram_glyph_writer_addr.sv
// Pixel address generator for one glyph pixel.
//   i_col, i_row : character cell position
//   i_gx, i_gy   : pixel position inside the 8x8 glyph
//   o_addr       : frame-buffer address y*FB_W + x, full ADDR_W width
// With FB_W = 640 the constant multiply reduces to (y<<9)+(y<<7).
module vram_glyph_writer_addr
  import vga_pkg::*;
#(
  parameter int FB_W   = H_RES,
  parameter int ADDR_W = vga_pkg::ADDR_W
) (
  input  logic [6:0]        i_col,
  input  logic [5:0]        i_row,
  input  logic [2:0]        i_gx,
  input  logic [2:0]        i_gy,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] w_x;
  logic [ADDR_W-1:0] w_y;

  // Glyphs are 8 pixels wide and tall, so cell*8+offset is a concatenation.
  assign w_x    = ADDR_W'({i_col, i_gx});
  assign w_y    = ADDR_W'({i_row, i_gy});
  assign o_addr = (w_y * ADDR_W'(FB_W)) + w_x;

endmodule

// File: rtl/vram_glyph_writer.sv
// Glyph / clear-screen writer for the 1-bit VGA frame buffer.
// Ports:
//   Clk, Rst              : clock, synchronous active-high reset
//   Cmd_Valid/Cmd_Ready   : command handshake
//   Cmd_Clear, Cmd_Char, Cmd_Col, Cmd_Row, Cmd_Inv : command fields
//   Font_Addr/Font_Data   : external font ROM, data valid 1 cycle after address
//   VRAM_Addr/Data/We     : frame-buffer write port, one pixel per cycle
//   Busy, Done            : command in progress / one-cycle completion pulse
//   Dbg_State             : current FSM state
// Handshake: a command is taken on the Clk edge where Cmd_Valid & Cmd_Ready
// are both high; the command inputs are sampled only on that edge. Cmd_Ready
// is high only in IDLE, so Cmd_Valid while busy is simply ignored and the
// requester has to hold it until Cmd_Ready returns.
module vram_glyph_writer
  import vga_pkg::*;
#(
  parameter int FB_W   = H_RES,
  parameter int FB_H   = V_RES,
  parameter int ADDR_W = $clog2(FB_W * FB_H)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Cmd_Valid,
  output logic              Cmd_Ready,
  input  logic              Cmd_Clear,
  input  logic [6:0]        Cmd_Char,
  input  logic [6:0]        Cmd_Col,
  input  logic [5:0]        Cmd_Row,
  input  logic              Cmd_Inv,
  output logic [9:0]        Font_Addr,
  input  logic [7:0]        Font_Data,
  output logic [ADDR_W-1:0] VRAM_Addr,
  output logic              VRAM_Data,
  output logic              VRAM_We,
  output logic              Busy,
  output logic              Done,
  output logic [2:0]        Dbg_State
);

  localparam logic [6:0]        L_COLS = 7'(FB_W / GLYPH_W);
  localparam logic [5:0]        L_ROWS = 6'(FB_H / GLYPH_H);
  localparam logic [ADDR_W-1:0] L_LAST = ADDR_W'(FB_W * FB_H - 1);

  writer_state_t     r_state;
  writer_state_t     w_next;

  logic [6:0]        r_char;
  logic [6:0]        r_col;
  logic [5:0]        r_row;
  logic              r_inv;
  logic [2:0]        r_gx;
  logic [2:0]        r_gy;
  logic [7:0]        r_font_row;
  logic [9:0]        r_font_hold;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] r_vram_addr;   // last written address, held while We=0
  logic              r_vram_data;   // last written data, held while We=0

  logic [ADDR_W-1:0] w_glyph_addr;
  logic              w_glyph_bit;

  vram_glyph_writer_addr #(
    .FB_W   (FB_W),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .i_col  (r_col),
    .i_row  (r_row),
    .i_gx   (r_gx),
    .i_gy   (r_gy),
    .o_addr (w_glyph_addr)
  );

  // Font bit 7 is the leftmost pixel.
  assign w_glyph_bit = r_font_row[3'd7 - r_gx] ^ r_inv;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (Cmd_Valid) begin
          if (Cmd_Clear)                                  w_next = CLEAR;
          else if ((Cmd_Col >= L_COLS) || (Cmd_Row >= L_ROWS)) w_next = FINISH;
          else                                            w_next = FETCH;
        end
      end
      FETCH:  w_next = WAIT;
      WAIT:   w_next = WRITE;
      WRITE: begin
        if (r_gx == 3'd7) w_next = (r_gy == 3'd7) ? FINISH : FETCH;
      end
      CLEAR: begin
        if (r_clr_addr == L_LAST) w_next = FINISH;
      end
      FINISH: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= IDLE;
      r_char      <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_inv       <= 1'b0;
      r_gx        <= '0;
      r_gy        <= '0;
      r_font_row  <= '0;
      r_font_hold <= '0;
      r_clr_addr  <= '0;
      r_vram_addr <= '0;
      r_vram_data <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (Cmd_Valid) begin
            r_char     <= Cmd_Char;
            r_col      <= Cmd_Col;
            r_row      <= Cmd_Row;
            r_inv      <= Cmd_Inv;
            r_gx       <= '0;
            r_gy       <= '0;
            r_clr_addr <= '0;
          end
        end
        FETCH: r_font_hold <= {r_char, r_gy};
        WAIT:  r_font_row  <= Font_Data;
        WRITE: begin
          r_gx        <= r_gx + 3'd1;
          if (r_gx == 3'd7) r_gy <= r_gy + 3'd1;
          r_vram_addr <= w_glyph_addr;
          r_vram_data <= w_glyph_bit;
        end
        CLEAR: begin
          r_clr_addr  <= r_clr_addr + 1'b1;
          r_vram_addr <= r_clr_addr;
          r_vram_data <= r_inv;
        end
        default: ;
      endcase
    end
  end

  // Write port is live only in WRITE/CLEAR; otherwise it shows the last write.
  always_comb begin
    VRAM_We   = 1'b0;
    VRAM_Addr = r_vram_addr;
    VRAM_Data = r_vram_data;
    Font_Addr = r_font_hold;
    case (r_state)
      FETCH: Font_Addr = {r_char, r_gy};
      WRITE: begin
        VRAM_We   = 1'b1;
        VRAM_Addr = w_glyph_addr;
        VRAM_Data = w_glyph_bit;
      end
      CLEAR: begin
        VRAM_We   = 1'b1;
        VRAM_Addr = r_clr_addr;
        VRAM_Data = r_inv;
      end
      default: ;
    endcase
  end

  assign Cmd_Ready = (r_state == IDLE);
  assign Busy      = ~Cmd_Ready;
  assign Done      = (r_state == FINISH);
  assign Dbg_State = r_state;

endmodule

// File: tb/tb_vram_glyph_writer.sv
module tb_vram_glyph_writer;

  localparam int FB_W = 128;
  localparam int FB_H = 64;
  localparam int AW   = 13;
  localparam int COLS = FB_W / 8;
  localparam int ROWS = FB_H / 8;
  localparam int NPIX = FB_W * FB_H;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_clear = 1'b0;
  logic [6:0]    cmd_char  = '0;
  logic [6:0]    cmd_col   = '0;
  logic [5:0]    cmd_row   = '0;
  logic          cmd_inv   = 1'b0;
  logic [9:0]    font_addr;
  logic [7:0]    font_data = '0;
  logic [AW-1:0] vram_addr;
  logic          vram_data;
  logic          vram_we;
  logic          busy;
  logic          done;
  logic [2:0]    dbg_state;

  vram_glyph_writer #(
    .FB_W   (FB_W),
    .FB_H   (FB_H),
    .ADDR_W (AW)
  ) dut (
    .Clk       (clk),
    .Rst       (rst),
    .Cmd_Valid (cmd_valid),
    .Cmd_Ready (cmd_ready),
    .Cmd_Clear (cmd_clear),
    .Cmd_Char  (cmd_char),
    .Cmd_Col   (cmd_col),
    .Cmd_Row   (cmd_row),
    .Cmd_Inv   (cmd_inv),
    .Font_Addr (font_addr),
    .Font_Data (font_data),
    .VRAM_Addr (vram_addr),
    .VRAM_Data (vram_data),
    .VRAM_We   (vram_we),
    .Busy      (busy),
    .Done      (done),
    .Dbg_State (dbg_state)
  );

  // font ROM model: random contents, 1-cycle registered read
  logic [7:0] rom [0:1023];
  always @(posedge clk) font_data <= rom[font_addr];

  // scoreboard state
  logic [AW:0] exp_q[$];   // {addr, data}
  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int done_seen = 0;
  int exp_done = 0;
  int last_addr = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // reference model: what the frame buffer should receive for one command
  task automatic model_cmd(input bit clr, input int ch, input int col, input int row, input bit inv);
    logic [7:0] fr;
    if (clr) begin
      for (int a = 0; a < NPIX; a++) exp_q.push_back({AW'(a), inv});
    end else if (col < COLS && row < ROWS) begin
      for (int gy = 0; gy < 8; gy++) begin
        fr = rom[ch * 8 + gy];
        for (int gx = 0; gx < 8; gx++)
          exp_q.push_back({AW'((row * 8 + gy) * FB_W + col * 8 + gx), fr[7 - gx] ^ inv});
      end
    end
    exp_done++;
  endtask

  // monitor: pops one expectation for every write the DUT presents
  always @(negedge clk) begin
    logic [AW:0] e;
    if (!rst) begin
      if (vram_we) begin
        total++;
        wr_cnt++;
        last_addr = int'(vram_addr);
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got addr=%0d data=%0b expected no write", vram_addr, vram_data);
        end else begin
          e = exp_q.pop_front();
          if ({vram_addr, vram_data} !== e) begin
            bad++;
            $display("FAIL pixel_write: got addr=%0d data=%0b expected addr=%0d data=%0b",
                     vram_addr, vram_data, e[AW:1], e[0]);
          end
        end
      end
      if (done) done_seen++;
    end
  end

  // driver: wait for Cmd_Ready, present command for exactly the accepting edge
  task automatic send(input bit clr, input int ch, input int col, input int row, input bit inv);
    int t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_clear = clr;
    cmd_char  = 7'(ch);
    cmd_col   = 7'(col);
    cmd_row   = 6'(row);
    cmd_inv   = inv;
    cmd_valid = 1'b1;
    model_cmd(clr, ch, col, row, inv);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // wait for Done (bounded); pulses Cmd_Valid with junk at the given cycle offsets
  task automatic wait_done(input string nm, input int pulse_a, input int pulse_b);
    int t = 0;
    @(negedge clk);
    while (!done && t < NPIX + 200) begin
      if (t == pulse_a || t == pulse_b) begin
        cmd_clear = 1'b0;
        cmd_col   = 7'd1;
        cmd_row   = 6'd1;
        cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    cmd_valid = 1'b0;
    check({nm, "_done"}, 32'(done), 32'd1);
    @(negedge clk);
    check({nm, "_ready_after"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int snap;
    int n;
    for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);

    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // idle after reset
    check("rst_vram_addr", 32'(vram_addr), 32'd0);
    check("rst_vram_data", 32'(vram_data), 32'd0);
    check("rst_font_addr", 32'(font_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(cmd_ready), 32'd1);
      check("idle_we", 32'(vram_we), 32'd0);
      check("idle_done", 32'(done), 32'd0);
    end

    // 'A' at the origin
    snap = wr_cnt;
    send(0, 'h41, 0, 0, 0);
    wait_done("glyph_a", -1, -1);
    check("glyph_a_writes", 32'(wr_cnt - snap), 32'd64);
    check("glyph_a_last", 32'(last_addr), 32'(7 * FB_W + 7));

    // bottom-right cell, inverted
    snap = wr_cnt;
    send(0, $urandom_range(0, 127), COLS - 1, ROWS - 1, 1);
    wait_done("glyph_br", -1, -1);
    check("glyph_br_writes", 32'(wr_cnt - snap), 32'd64);
    check("glyph_br_last", 32'(last_addr), 32'(NPIX - 1));

    // column out of range: Done on the cycle right after accept, no writes
    snap = wr_cnt;
    send(0, 'h42, COLS, 0, 0);
    @(negedge clk);
    check("oor_col_done_lat", 32'(done), 32'd1);
    @(negedge clk);
    check("oor_col_ready", 32'(cmd_ready), 32'd1);
    check("oor_col_writes", 32'(wr_cnt - snap), 32'd0);

    // row out of range
    snap = wr_cnt;
    send(0, 'h43, 3, ROWS, 1);
    @(negedge clk);
    check("oor_row_done_lat", 32'(done), 32'd1);
    check("oor_row_writes", 32'(wr_cnt - snap), 32'd0);

    // random glyphs, some out of range
    for (int k = 0; k < 12; k++) begin
      send(0, $urandom_range(0, 127), $urandom_range(0, COLS + 1),
           $urandom_range(0, ROWS + 1), 1'($urandom));
      wait_done("rand_glyph", -1, -1);
    end

    // clear to 1 with ignored Cmd_Valid pulses along the way
    snap = wr_cnt;
    send(1, 0, 0, 0, 1);
    wait_done("clear1", 50, 3000);
    check("clear1_writes", 32'(wr_cnt - snap), 32'(NPIX));
    check("clear1_last", 32'(last_addr), 32'(NPIX - 1));

    // clear to 0
    snap = wr_cnt;
    send(1, 'h7f, 5, 5, 0);
    wait_done("clear0", -1, -1);
    check("clear0_writes", 32'(wr_cnt - snap), 32'(NPIX));

    // reset at gx=3 of the first glyph row
    send(0, 'h55, 2, 1, 0);
    n = 0;
    for (int t = 0; t < 200 && n < 4; t++) begin
      @(negedge clk);
      if (vram_we) n++;
    end
    check("rst_mid_reached_gx3", 32'(n), 32'd4);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_we", 32'(vram_we), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_ready", 32'(cmd_ready), 32'd1);
    check("rst_mid_addr", 32'(vram_addr), 32'd0);
    check("rst_mid_data", 32'(vram_data), 32'd0);
    check("rst_mid_font", 32'(font_addr), 32'd0);
    check("rst_mid_pending", 32'(exp_q.size()), 32'd60);
    exp_q.delete();
    exp_done--;
    @(negedge clk) rst = 1'b0;

    // command after the aborted one runs normally
    snap = wr_cnt;
    send(0, 'h30, 4, 2, 1);
    wait_done("after_rst", -1, -1);
    check("after_rst_writes", 32'(wr_cnt - snap), 32'd64);

    repeat (5) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_done_count", 32'(done_seen), 32'(exp_done));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
